// File: rtl/mod997_pkg.sv
// Shared mod-997 constants, controller state encoding and residue helpers
// used by the digit-serial multiplier and other mod-997 blocks.
package mod997_pkg;

    localparam int MOD     = 997;
    localparam int DIGIT_W = 3;
    localparam int NDIG    = 4;
    localparam int RES_W   = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Both inputs are < MOD, so a single conditional subtract is enough.
    function automatic logic [RES_W-1:0] mod_add(input logic [RES_W-1:0] a,
                                                 input logic [RES_W-1:0] b);
        logic [RES_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= (RES_W+1)'(MOD)) ? RES_W'(s - (RES_W+1)'(MOD)) : s[RES_W-1:0];
    endfunction

    // Radix-8 digit idx of a 10-bit operand; bits above bit 9 read as zero.
    function automatic logic [DIGIT_W-1:0] digit(input logic [RES_W-1:0] op,
                                                 input logic [1:0]       idx);
        logic [DIGIT_W*NDIG-1:0] ext;
        ext = (DIGIT_W*NDIG)'(op);
        return ext[idx*DIGIT_W +: DIGIT_W];
    endfunction

endpackage

// File: rtl/mod997_mult_seq_acc.sv
// Mod-997 accumulator: adds one residue per enabled cycle, with a
// synchronous clear that takes priority over enable.
module mod997_acc
    import mod997_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [RES_W-1:0] z,
    output logic [RES_W-1:0] acc
);

    // NOTE: sequential state is written with <= only, so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= mod_add(acc, z);
        end
    end

endmodule

// File: rtl/mod997_mult_seq.sv
// Digit-serial mod-997 multiplier controller: walks the 16 radix-8 digit
// pairs through the external weight LUT bank and accumulates the residues.
module mod997_mult_seq
    import mod997_pkg::*;
#(
    parameter int REG_LUT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RES_W-1:0]   in_a,
    input  logic [RES_W-1:0]   in_b,
    output logic [DIGIT_W-1:0] lut_x,
    output logic [DIGIT_W-1:0] lut_y,
    output logic [2:0]         lut_k,
    input  logic [RES_W-1:0]   lut_z,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RES_W-1:0]   out_z
);

    state_t           state;
    logic [RES_W-1:0] a_q;
    logic [RES_W-1:0] b_q;
    logic [3:0]       cnt;
    logic [3:0]       cnt_nxt;
    logic             drain;
    logic             addr_valid;
    logic             acc_clr;
    logic             pipe_valid;
    logic             pipe_last;
    logic [RES_W-1:0] z_q;
    logic             z_valid;
    logic             z_last;
    logic [RES_W-1:0] z_acc;
    logic [RES_W-1:0] acc;

    // NOTE: every always_comb output gets a value on every path, so no
    // latches are inferred.
    always_comb begin
        addr_valid = (state == RUN) && !drain;
        acc_clr    = (state == IDLE) && in_valid;
        cnt_nxt    = cnt + 4'd1;
        if (REG_LUT != 0) begin
            z_acc   = z_q;
            z_valid = pipe_valid;
            z_last  = pipe_last;
        end else begin
            z_acc   = lut_z;
            z_valid = addr_valid;
            z_last  = addr_valid && (cnt == 4'd15);
        end
    end

    // Optional retiming stage; it tracks which address each sample belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_q        <= '0;
            pipe_valid <= 1'b0;
            pipe_last  <= 1'b0;
        end else begin
            z_q        <= lut_z;
            pipe_valid <= addr_valid;
            pipe_last  <= addr_valid && (cnt == 4'd15);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            drain     <= 1'b0;
            lut_x     <= '0;
            lut_y     <= '0;
            lut_k     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        cnt      <= '0;
                        drain    <= 1'b0;
                        lut_x    <= in_a[DIGIT_W-1:0];
                        lut_y    <= in_b[DIGIT_W-1:0];
                        lut_k    <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (addr_valid) begin
                        cnt <= cnt_nxt;
                        if (cnt == 4'd15) begin
                            drain <= 1'b1;
                            lut_x <= '0;
                            lut_y <= '0;
                            lut_k <= '0;
                        end else begin
                            lut_x <= digit(a_q, cnt_nxt[3:2]);
                            lut_y <= digit(b_q, cnt_nxt[1:0]);
                            lut_k <= {1'b0, cnt_nxt[3:2]} + {1'b0, cnt_nxt[1:0]};
                        end
                    end
                    if (z_valid && z_last) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mod997_acc u_acc (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (z_valid),
        .z   (z_acc),
        .acc (acc)
    );

    assign out_z = acc;

endmodule

// File: tb/tb_mod997_mult_seq.sv
// Bench for mod997_mult_seq: instance 0 without and instance 1 with the
// registered LUT stage, each driven by a behavioural weight-LUT model.
module tb_mod997_mult_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [9:0] in_a      [2];
    logic [9:0] in_b      [2];
    logic [2:0] lut_x     [2];
    logic [2:0] lut_y     [2];
    logic [2:0] lut_k     [2];
    logic [9:0] lut_z     [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [9:0] out_z     [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [9:0] lut_model(input logic [2:0] x,
                                             input logic [2:0] y,
                                             input logic [2:0] k);
        int p;
        p = 1;
        for (int i = 0; i < int'(k); i++) p = (p * 8) % 997;
        return 10'((int'(x) * int'(y) * p) % 997);
    endfunction

    assign lut_z[0] = lut_model(lut_x[0], lut_y[0], lut_k[0]);
    assign lut_z[1] = lut_model(lut_x[1], lut_y[1], lut_k[1]);

    mod997_mult_seq #(.REG_LUT(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .lut_x(lut_x[0]), .lut_y(lut_y[0]),
        .lut_k(lut_k[0]), .lut_z(lut_z[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_z(out_z[0])
    );

    mod997_mult_seq #(.REG_LUT(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .lut_x(lut_x[1]), .lut_y(lut_y[1]),
        .lut_k(lut_k[1]), .lut_z(lut_z[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_z(out_z[1])
    );

    typedef struct {
        logic [9:0] a;
        logic [9:0] b;
        logic [9:0] z;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out", name);
    endtask

    // Offer a pair on the next negedge once in_ready is seen; waited = idle cycles.
    task automatic start_op(input int d, input logic [9:0] a, input logic [9:0] b,
                            output int waited);
        waited = 0;
        @(negedge clk);
        while (!in_ready[d] && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready[d]) timeout("start_op");
        in_valid[d] = 1'b1;
        in_a[d]     = a;
        in_b[d]     = b;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        in_a[d]     = 10'h3ff;
        in_b[d]     = 10'h3ff;
    endtask

    // lat counts cycles after the handshake cycle until out_valid is seen.
    task automatic wait_done(input int d, output int lat, output logic [9:0] z);
        lat = 1;
        @(negedge clk);
        while (!out_valid[d] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid[d]) timeout("wait_done");
        z = out_z[d];
    endtask

    task automatic run_vec(input int d, input vec_t v, input int exp_lat, input string tag);
        int         lat;
        int         w;
        logic [9:0] z;
        start_op(d, v.a, v.b, w);
        wait_done(d, lat, z);
        check($sformatf("%s latency", tag), lat, exp_lat);
        check($sformatf("%s out_z a=%0d b=%0d", tag, v.a, v.b), int'(z), int'(v.z));
        @(posedge clk);
    endtask

    task automatic lut_seq(input int d);
        int         adig[4];
        int         bdig[4];
        int         lat;
        int         w;
        logic [9:0] z;
        adig = '{4, 3, 2, 1};
        bdig = '{5, 6, 7, 1};
        start_op(d, 10'o1234, 10'o1765, w);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            check($sformatf("lut{x,y,k} dut%0d cycle %0d", d, c),
                  int'({lut_x[d], lut_y[d], lut_k[d]}),
                  (adig[c / 4] << 6) | (bdig[c % 4] << 3) | (c / 4 + c % 4));
        end
        wait_done(d, lat, z);
        check($sformatf("lut_seq dut%0d out_z", d), int'(z), 718);
        @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         w;
        int         got;
        int         exp_z;
        logic [9:0] z;
        logic [9:0] ra;
        logic [9:0] rb;

        vecs[0] = '{a: 10'd0,    b: 10'd0,    z: 10'd0};
        vecs[1] = '{a: 10'd996,  b: 10'd996,  z: 10'd1};
        vecs[2] = '{a: 10'd8,    b: 10'd64,   z: 10'd512};
        vecs[3] = '{a: 10'd1023, b: 10'd1023, z: 10'd676};
        vecs[4] = '{a: 10'd668,  b: 10'd1013, z: 10'd718};
        vecs[5] = '{a: 10'd997,  b: 10'd5,    z: 10'd0};
        vecs[6] = '{a: 10'd1,    b: 10'd996,  z: 10'd996};
        vecs[7] = '{a: 10'd100,  b: 10'd200,  z: 10'd60};

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_a[d]      = '0;
            in_b[d]      = '0;
            out_ready[d] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset in_ready dut%0d", d), int'(in_ready[d]), 1);
            check($sformatf("reset out_valid dut%0d", d), int'(out_valid[d]), 0);
            check($sformatf("reset out_z dut%0d", d), int'(out_z[d]), 0);
            check($sformatf("reset lut dut%0d", d),
                  int'({lut_x[d], lut_y[d], lut_k[d]}), 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(0, vecs[i], 17, $sformatf("vec%0d dut0", i));
            run_vec(1, vecs[i], 18, $sformatf("vec%0d dut1", i));
        end

        lut_seq(0);
        lut_seq(1);

        // Backpressure in DONE: result and handshake state must hold.
        out_ready[0] = 1'b0;
        start_op(0, 10'd100, 10'd200, w);
        wait_done(0, lat, z);
        check("hold first out_z", int'(z), 60);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("hold out_valid c%0d", c), int'(out_valid[0]), 1);
            check($sformatf("hold out_z c%0d", c), int'(out_z[0]), 60);
            check($sformatf("hold in_ready c%0d", c), int'(in_ready[0]), 0);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("release in_ready", int'(in_ready[0]), 1);
        check("release out_valid", int'(out_valid[0]), 0);

        // Reset in the middle of RUN discards the operation.
        start_op(0, 10'd500, 10'd600, w);
        for (int c = 1; c < 7; c++) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrun rst in_ready", int'(in_ready[0]), 1);
        check("midrun rst out_valid", int'(out_valid[0]), 0);
        @(posedge clk);
        run_vec(0, '{a: 10'd2, b: 10'd3, z: 10'd6}, 17, "after rst");

        // rst wins over a simultaneous in_valid.
        @(negedge clk);
        rst         = 1'b1;
        in_valid[0] = 1'b1;
        in_a[0]     = 10'd5;
        in_b[0]     = 10'd5;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        in_valid[0] = 1'b0;
        @(negedge clk);
        check("rst+valid in_ready", int'(in_ready[0]), 1);
        check("rst+valid lut_x", int'(lut_x[0]), 0);

        // Back-to-back random pairs with random consumer backpressure.
        for (int n = 0; n < 1000; n++) begin
            ra    = 10'($urandom_range(0, 1023));
            rb    = 10'($urandom_range(0, 1023));
            exp_z = (int'(ra) * int'(rb)) % 997;
            start_op(0, ra, rb, w);
            if (n > 0) check($sformatf("rand%0d idle wait", n), w, 0);
            got = 0;
            lat = 0;
            while (got == 0 && lat < 300) begin
                @(negedge clk);
                lat++;
                out_ready[0] = 1'($urandom_range(0, 1));
                if (out_valid[0] && out_ready[0]) begin
                    check($sformatf("rand%0d out_z a=%0d b=%0d", n, ra, rb),
                          int'(out_z[0]), exp_z);
                    got = 1;
                    @(posedge clk);
                end
            end
            if (got == 0) timeout($sformatf("rand%0d result", n));
        end
        out_ready[0] = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mod997_mult_seq.md
# mod997_mult_seq

Digit-serial controller for the mod-997 modular multiplier. It accepts two 10-bit operands over a valid/ready handshake and splits each operand into four radix-8 digits. It then walks all 16 digit pairs through the shared external 3x3 digit-product LUT bank (one table per weight 8^k mod 997; the k=3 table is the existing weight-512 instance). It accumulates the returned residues mod 997 and presents a*b mod 997 on a valid/ready output.

## Interface
Parameters:
- REG_LUT, default 0: 1 = register lut_z before accumulation, adding one cycle of latency.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  block can accept a pair (high only in IDLE)
- in_a  in  10  operand A, any value 0..1023
- in_b  in  10  operand B, any value 0..1023
- lut_x  out  3  A digit to LUT bank
- lut_y  out  3  B digit to LUT bank
- lut_k  out  3  weight select 0..6 (weight 8^k mod 997)
- lut_z  in  10  combinational LUT result (lut_x*lut_y*8^lut_k) mod 997, always < 997
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_z  out  10  (in_a*in_b) mod 997, range 0..996

## Operation
- Digits: a_i = A[3i+2:3i] for i=0..3. A[11:10] reads as zero, so a_3 is 0..1. Same rule for B.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid, latch A and B, clear acc and cnt, go to RUN.
- RUN: cnt is 4 bits = {i,j}, running 0..15 with i the A-digit index (outer) and j the B-digit index (inner).
  - Drive lut_x=a_i, lut_y=b_j, lut_k=i+j.
  - Each accumulate step: s = acc + z (11 bits, max 1992). acc <= (s >= 997) ? s-997 : s. Here z is lut_z, or its registered copy when REG_LUT=1.
  - Leave RUN after the 16th accumulate.
- DONE: out_valid=1, out_z=acc. When out_ready=1, go to IDLE. out_z holds stable while out_valid=1 and out_ready=0.
- No zero-digit skipping. Latency is fixed and independent of operand values.
- Inputs ≥997 are legal. The digit decomposition gives the correct residue for any 10-bit operand.
- in_a and in_b are ignored outside IDLE. in_valid during RUN or DONE is not accepted.
- Modulus 997, radix 8 and the digit count are fixed constants, not parameters.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_z=0, acc=0, cnt=0, lut_x=lut_y=lut_k=0.
- lut_x, lut_y and lut_k are registered outputs. lut_z is sampled in the same cycle the address is presented (LUT bank is combinational, must fit one cycle).
- REG_LUT=0:
  - Handshake at cycle T.
  - RUN occupies T+1..T+16.
  - out_valid rises at T+17.
- REG_LUT=1:
  - Accumulation trails the address by one cycle, and RUN lasts 17 cycles.
  - out_valid rises at T+18.
- Throughput: with out_ready held high, one result per 18 cycles (REG_LUT=0). The DONE cycle with out_ready=1 returns to IDLE. The next handshake can occur in the IDLE cycle immediately after. There is no combinational in_ready←out_ready path.
- Reset asserted in any state: the next cycle is IDLE with reset values. The in-flight operation is discarded and no partial out_valid is produced.
- A simultaneous rst and in_valid loses the pair; rst has priority.
- cnt wrap 15→0 coincides with the RUN exit. cnt is not used outside RUN.

## Structure
- Shared package mod997_pkg: localparam MOD=997, DIGIT_W=3, NDIG=4, RES_W=10, the state enum, and a function mod_add(a,b) implementing the conditional-subtract rule above (also used by other mod-997 blocks).
- Natural sub-module: mod997_acc (11-bit adder + compare/subtract + acc register, with clear and enable inputs).
- The LUT bank stays outside this block. The bench instantiates a behavioural model of (x*y*8^k) mod 997.

## Test plan
- a=0, b=0 → out_z=0, out_valid at handshake+17 (REG_LUT=0) and handshake+18 (REG_LUT=1).
- a=996, b=996 → out_z=1; a=8, b=64 → out_z=512; a=1023, b=1023 → out_z=676.
- Check lut_k sequence 0,1,2,3,1,2,3,4,…,6 across the 16 RUN cycles, and lut_x/lut_y matching the digits of a=0o1234 and b=0o1765 (0o = octal).
- Hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, out_z stable, in_ready=0. Then out_ready=1 → IDLE next cycle.
- Assert rst at RUN cycle 7 → next cycle in_ready=1, out_valid=0. The following a=2, b=3 returns 6.
- 1000 random back-to-back pairs with out_ready randomly toggled → every out_z equals (a*b)%997, in order, with no loss or duplication.
